counter_mod12_chk: RTL and testbench
====================================

COUNTER_MOD12_CHK -- requirements
Module: counter_mod12_chk

Interface
REQ-001 Parameter LOCK_N, default 2, SHALL set consecutive correct predictions needed to enter LOCK (legal 1..15).
REQ-002 Parameter ERR_W, default 8, SHALL set err_cnt width.
REQ-003 clk  in  1  single clock, all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 cnt_in  in  4  observed mod-12 count value.
REQ-006 load  in  1  observed load control driving the counter.
REQ-007 mode  in  1  observed direction control, 1 = up, 0 = down.
REQ-008 data_in  in  4  observed load value.
REQ-009 exp_out  out  4  predicted cnt_in for the next rising edge.
REQ-010 locked  out  1  high while state is LOCK.
REQ-011 err  out  1  one-cycle pulse on a mismatch while in LOCK.
REQ-012 err_cnt  out  ERR_W  saturating count of err pulses.
REQ-013 wrap_up / wrap_dn  out  1 each  one-cycle pulses on observed 11->0 (up) and 0->11 (down) transitions.
REQ-014 illegal  out  1  registered flag, cnt_in > 11 at the last edge.

Function
REQ-015 The block SHALL sample cnt_in, load, mode and data_in at every rising edge (sample k) and hold sample k as the reference for sample k+1.
REQ-016 Prediction from reference: load=1 -> data_in; else mode=1 -> 0 if cnt==11, else cnt+1 mod 16; else mode=0 -> 11 if cnt==0, else cnt-1.
REQ-017 Out-of-range values SHALL follow REQ-016 unchanged (up: 12->13->14->15->0; down: 13->12->11).
REQ-018 exp_out SHALL be registered and equal to the REQ-016 prediction computed from the latest sample.
REQ-019 FSM states: UNSYNC, HUNT, LOCK.
REQ-020 UNSYNC: first sample after reset is captured as reference only, no compare; next state HUNT, match counter = 0.
REQ-021 HUNT: match -> match counter +1; reaching LOCK_N -> LOCK; mismatch -> match counter = 0, stay HUNT, no err.
REQ-022 LOCK: match -> stay; mismatch -> err=1 next cycle, err_cnt +1 (saturate at all-ones), state HUNT, match counter = 0.
REQ-023 The block SHALL flag a mismatch only in LOCK; HUNT mismatches are silent.
REQ-024 wrap_up SHALL pulse when reference cnt==11, reference load=0, reference mode=1, current cnt_in==0; wrap_dn symmetrically for 0->11 with mode=0; independent of FSM state except UNSYNC (no pulse).
REQ-025 A load whose data_in equals the up/down prediction SHALL NOT produce a wrap pulse.
REQ-026 All outputs SHALL be registered; err, wrap_up, wrap_dn are single-cycle and deassert the following cycle unless re-triggered.
REQ-027 illegal SHALL track each sample independently of FSM state and SHALL NOT itself raise err.

Reset
REQ-028 rst=1 at an edge SHALL force UNSYNC, match counter 0, exp_out 0, locked 0, err 0, err_cnt 0, wrap_up 0, wrap_dn 0, illegal 0.
REQ-029 Reset mid-LOCK SHALL discard the reference; no err SHALL be reported for the sample at or after the reset edge.
REQ-030 Samples taken while rst=1 SHALL be ignored.

Structure
REQ-031 Shared package counter_mod12_pkg SHALL hold MOD_MAX = 4'd11, the FSM state enum, and the REQ-016 next-value function.
REQ-032 No sub-module; a single module with the package function suffices.

Verification
REQ-033 Reset, then up-count 0..11,0,1 with LOCK_N=2 -> locked high at 3rd sample, wrap_up pulses once at 11->0, err_cnt=0.
REQ-034 Locked down-count 2,1,0,11,10 -> wrap_dn pulse once, exp_out sequence 1,0,11,10,9.
REQ-035 Locked up-count, cnt_in forced 5->7 -> err one cycle, err_cnt=1, locked low, relock after 2 correct samples.
REQ-036 load=1, data_in=13 from cnt 4, then up -> cnt 13,14,15,0 matched, illegal high for 13-15, no err, no wrap_up.
REQ-037 rst asserted while locked with err_cnt=3 -> all outputs 0 next cycle, UNSYNC, no err on the first post-reset sample.
REQ-038 ERR_W=2, 5 injected mismatches, each after relock -> err_cnt saturates at 3.

Source files
------------

// File: rtl/counter_mod12_pkg.sv
// Shared definitions for the mod-12 counter checker: count limit, FSM states
// and the next-count prediction rule.
package counter_mod12_pkg;

    localparam logic [3:0] MOD_MAX = 4'd11;

    typedef enum logic [1:0] {
        UNSYNC = 2'd0,
        HUNT   = 2'd1,
        LOCK   = 2'd2
    } state_t;

    // Out-of-range counts are not clamped: 12..15 keep counting up to 0,
    // and 13 counts down to 12.
    function automatic logic [3:0] next_val(
        input logic [3:0] cnt,
        input logic       load,
        input logic       mode,
        input logic [3:0] data
    );
        logic [3:0] nxt;
        if (load) begin
            nxt = data;
        end else if (mode) begin
            nxt = (cnt == MOD_MAX) ? 4'd0 : cnt + 4'd1;
        end else begin
            nxt = (cnt == 4'd0) ? MOD_MAX : cnt - 4'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/counter_mod12_chk.sv
// Passive checker for an external mod-12 up/down/load counter: predicts the
// next count, locks on after LOCK_N correct predictions and reports mismatches.
module counter_mod12_chk
    import counter_mod12_pkg::*;
#(
    parameter int unsigned LOCK_N = 2,
    parameter int unsigned ERR_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       cnt_in,
    input  logic             load,
    input  logic             mode,
    input  logic [3:0]       data_in,
    output logic [3:0]       exp_out,
    output logic             locked,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt,
    output logic             wrap_up,
    output logic             wrap_dn,
    output logic             illegal
);

    localparam logic [4:0] LOCK_TGT = 5'(LOCK_N);

    state_t           state_q;
    state_t           state_d;
    logic [3:0]       match_q;
    logic [3:0]       match_d;
    logic [3:0]       ref_cnt;
    logic             ref_load;
    logic             ref_mode;

    logic             hit;
    logic [4:0]       match_sum;
    logic             err_d;
    logic [ERR_W-1:0] err_cnt_d;
    logic             wrap_up_d;
    logic             wrap_dn_d;

    // exp_out already holds the prediction made from the reference sample.
    assign hit       = (cnt_in == exp_out);
    assign match_sum = {1'b0, match_q} + 5'd1;

    always_comb begin
        state_d   = state_q;
        match_d   = match_q;
        err_d     = 1'b0;
        err_cnt_d = err_cnt;
        wrap_up_d = 1'b0;
        wrap_dn_d = 1'b0;

        case (state_q)
            UNSYNC: begin
                state_d = HUNT;
                match_d = '0;
            end
            HUNT: begin
                if (hit) begin
                    match_d = match_sum[3:0];
                    if (match_sum >= LOCK_TGT) begin
                        state_d = LOCK;
                    end
                end else begin
                    match_d = '0;
                end
            end
            LOCK: begin
                if (!hit) begin
                    err_d   = 1'b1;
                    state_d = HUNT;
                    match_d = '0;
                    if (err_cnt != '1) begin
                        err_cnt_d = err_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_d = UNSYNC;
                match_d = '0;
            end
        endcase

        // A load never counts as a wrap, even if it lands on the wrapped value.
        if (state_q != UNSYNC && !ref_load) begin
            wrap_up_d = ref_mode  && (ref_cnt == MOD_MAX) && (cnt_in == 4'd0);
            wrap_dn_d = !ref_mode && (ref_cnt == 4'd0)    && (cnt_in == MOD_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= UNSYNC;
            match_q  <= '0;
            ref_cnt  <= '0;
            ref_load <= 1'b0;
            ref_mode <= 1'b0;
            exp_out  <= '0;
            locked   <= 1'b0;
            err      <= 1'b0;
            err_cnt  <= '0;
            wrap_up  <= 1'b0;
            wrap_dn  <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            state_q  <= state_d;
            match_q  <= match_d;
            ref_cnt  <= cnt_in;
            ref_load <= load;
            ref_mode <= mode;
            exp_out  <= next_val(cnt_in, load, mode, data_in);
            locked   <= (state_d == LOCK);
            err      <= err_d;
            err_cnt  <= err_cnt_d;
            wrap_up  <= wrap_up_d;
            wrap_dn  <= wrap_dn_d;
            illegal  <= (cnt_in > MOD_MAX);
        end
    end

endmodule

// File: tb/tb_counter_mod12_chk.sv
// Self-checking bench for counter_mod12_chk: directed scenarios with literal
// expectations, then random traffic against a behavioural model.
module tb_counter_mod12_chk;

    logic       clk;
    logic       rst;
    logic [3:0] cnt_in;
    logic       load;
    logic       mode;
    logic [3:0] data_in;

    logic [3:0] exp_out, w2_exp_out;
    logic       locked, w2_locked;
    logic       err, w2_err;
    logic [7:0] err_cnt;
    logic [1:0] w2_err_cnt;
    logic       wrap_up, w2_wrap_up;
    logic       wrap_dn, w2_wrap_dn;
    logic       illegal, w2_illegal;

    int n_checks = 0;
    int n_errors = 0;

    counter_mod12_chk #(.LOCK_N(2), .ERR_W(8)) dut (
        .clk(clk), .rst(rst), .cnt_in(cnt_in), .load(load), .mode(mode),
        .data_in(data_in), .exp_out(exp_out), .locked(locked), .err(err),
        .err_cnt(err_cnt), .wrap_up(wrap_up), .wrap_dn(wrap_dn), .illegal(illegal)
    );

    counter_mod12_chk #(.LOCK_N(2), .ERR_W(2)) dut_w2 (
        .clk(clk), .rst(rst), .cnt_in(cnt_in), .load(load), .mode(mode),
        .data_in(data_in), .exp_out(w2_exp_out), .locked(w2_locked), .err(w2_err),
        .err_cnt(w2_err_cnt), .wrap_up(w2_wrap_up), .wrap_dn(w2_wrap_dn),
        .illegal(w2_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: previous sample, streak of correct predictions,
    // lock flag and total mismatch count.
    function automatic int predict(input int c, input bit l, input bit m, input int d);
        if (l) return d;
        if (m) return (c == 11) ? 0 : (c + 1) % 16;
        return (c == 0) ? 11 : c - 1;
    endfunction

    bit m_started = 0;
    bit m_synced, m_locked, m_err, m_wup, m_wdn, m_ill;
    int m_exp, m_streak, m_errs;
    int p_cnt; bit p_load, p_mode;

    always @(posedge clk) begin
        m_started = 1;
        if (rst) begin
            m_synced = 0; m_locked = 0; m_err = 0; m_wup = 0; m_wdn = 0;
            m_ill = 0; m_exp = 0; m_streak = 0; m_errs = 0;
        end else begin
            int c;
            bit match;
            c = int'(cnt_in);
            m_err = 0; m_wup = 0; m_wdn = 0;
            m_ill = (c > 11);
            if (m_synced) begin
                match = (c == m_exp);
                m_wup = !p_load && p_mode  && p_cnt == 11 && c == 0;
                m_wdn = !p_load && !p_mode && p_cnt == 0  && c == 11;
                if (m_locked) begin
                    if (!match) begin
                        m_err = 1; m_errs++; m_locked = 0; m_streak = 0;
                    end
                end else if (match) begin
                    m_streak++;
                    if (m_streak >= 2) m_locked = 1;
                end else begin
                    m_streak = 0;
                end
            end
            m_synced = 1;
            p_cnt = c; p_load = load; p_mode = mode;
            m_exp = predict(c, load, mode, int'(data_in));
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            chk("exp_out", int'(exp_out), m_exp);
            chk("locked", int'(locked), int'(m_locked));
            chk("err", int'(err), int'(m_err));
            chk("err_cnt", int'(err_cnt), (m_errs > 255) ? 255 : m_errs);
            chk("wrap_up", int'(wrap_up), int'(m_wup));
            chk("wrap_dn", int'(wrap_dn), int'(m_wdn));
            chk("illegal", int'(illegal), int'(m_ill));
            chk("w2_exp_out", int'(w2_exp_out), m_exp);
            chk("w2_locked", int'(w2_locked), int'(m_locked));
            chk("w2_err", int'(w2_err), int'(m_err));
            chk("w2_err_cnt", int'(w2_err_cnt), (m_errs > 3) ? 3 : m_errs);
            chk("w2_wraps", int'({w2_wrap_up, w2_wrap_dn}), int'({m_wup, m_wdn}));
            chk("w2_illegal", int'(w2_illegal), int'(m_ill));
        end
    end

    task automatic step(input int c, input bit l, input bit m, input int d);
        rst = 1'b0; cnt_in = 4'(c); load = l; mode = m; data_in = 4'(d);
        @(posedge clk);
        #2;
    endtask

    task automatic up(input int c);
        step(c, 1'b0, 1'b1, 0);
    endtask

    task automatic dn(input int c);
        step(c, 1'b0, 1'b0, 0);
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1; cnt_in = 4'd7; load = 1'b0; mode = 1'b1; data_in = 4'd0;
        repeat (cycles) @(posedge clk);
        #2;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_exp_out"}, int'(exp_out), 0);
        chk({tag, "_flags"}, int'({locked, err, wrap_up, wrap_dn, illegal}), 0);
        chk({tag, "_err_cnt"}, int'(err_cnt), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int wu, wd, errs_seen, cur, bad;
        int dn_seq[5]  = '{2, 1, 0, 11, 10};
        int dn_exp[5]  = '{1, 0, 11, 10, 9};

        rst = 1'b1; cnt_in = '0; load = 1'b0; mode = 1'b0; data_in = '0;
        do_reset(2);
        chk_all_zero("reset");

        // Up-count 0..11,0,1: lock on the third sample, one wrap_up.
        wu = 0;
        for (int i = 0; i < 12; i++) begin
            up(i);
            if (i == 1) chk("lock_2nd_sample", int'(locked), 0);
            if (i == 2) chk("lock_3rd_sample", int'(locked), 1);
            wu += int'(wrap_up);
        end
        up(0); wu += int'(wrap_up);
        up(1); wu += int'(wrap_up);
        chk("up_wrap_count", wu, 1);
        chk("up_err_cnt", int'(err_cnt), 0);
        chk("up_exp_after_1", int'(exp_out), 2);

        // Down-count through 0 -> 11.
        wd = 0;
        for (int i = 0; i < 5; i++) begin
            dn(dn_seq[i]);
            chk("dn_exp_out", int'(exp_out), dn_exp[i]);
            wd += int'(wrap_dn);
        end
        chk("dn_wrap_count", wd, 1);
        chk("dn_locked", int'(locked), 1);

        // Mismatch 5 -> 7 while locked, then relock.
        up(9); up(10); up(11);
        for (int i = 0; i <= 5; i++) up(i);
        chk("pre_err_locked", int'(locked), 1);
        up(7);
        chk("mm_err", int'(err), 1);
        chk("mm_err_cnt", int'(err_cnt), 1);
        chk("mm_locked", int'(locked), 0);
        up(8);
        chk("mm_err_cleared", int'(err), 0);
        chk("mm_relock_1", int'(locked), 0);
        up(9);
        chk("mm_relock_2", int'(locked), 1);

        // Load of 13 then count through 13,14,15,0.
        up(10); up(11); up(0); up(1); up(2); up(3);
        step(4, 1'b1, 1'b1, 13);
        chk("load_exp_out", int'(exp_out), 13);
        wu = 0; errs_seen = 0;
        for (int v = 13; v <= 16; v++) begin
            up(v % 16);
            chk("oor_illegal", int'(illegal), (v <= 15) ? 1 : 0);
            wu += int'(wrap_up);
            errs_seen += int'(err);
        end
        chk("oor_wrap_up", wu, 0);
        chk("oor_err", errs_seen, 0);
        chk("oor_err_cnt", int'(err_cnt), 1);

        // Two more mismatches to bring err_cnt to 3.
        up(5);  up(6); up(7);
        up(0);  up(1); up(2);
        chk("three_errs", int'(err_cnt), 3);
        chk("three_locked", int'(locked), 1);

        // Reset while locked: everything clears, first sample never errs.
        do_reset(1);
        chk_all_zero("midreset");
        up(9);
        chk("post_rst_err_a", int'(err), 0);
        chk("post_rst_lock_a", int'(locked), 0);
        up(3);
        chk("post_rst_err_b", int'(err), 0);

        // Five relock-then-mismatch rounds: narrow counter saturates at 3.
        do_reset(1);
        up(0);
        cur = 0;
        for (int k = 0; k < 5; k++) begin
            repeat (2) begin
                cur = (cur == 11) ? 0 : cur + 1;
                up(cur);
            end
            chk("sat_relock", int'(locked), 1);
            bad = (cur + 5) % 12;
            up(bad);
            cur = bad;
        end
        chk("sat_w2_err_cnt", int'(w2_err_cnt), 3);
        chk("sat_w8_err_cnt", int'(err_cnt), 5);

        // Random traffic, mostly following the prediction so locks occur.
        for (int n = 0; n < 2000; n++) begin
            int c, d;
            bit l, m;
            if ($urandom_range(63) == 0) begin
                do_reset(1);
            end else begin
                c = ($urandom_range(7) == 0 || !m_synced) ? int'($urandom_range(15)) : m_exp;
                l = ($urandom_range(7) == 0);
                m = $urandom_range(1) == 1;
                d = ($urandom_range(3) == 0) ? int'($urandom_range(15)) : int'($urandom_range(11));
                step(c, l, m, d);
            end
        end

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
